cnn_image_feeder: RTL



---
 rtl/cnn_pkg.sv | 17 +
 rtl/cnn_image_feeder.sv | 109 ++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN image feeder: frame geometry, FSM encoding and prediction codes.
package cnn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int PIXEL_W    = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_LOAD   = 2'd0;
  localparam state_t S_START  = 2'd1;
  localparam state_t S_WAIT   = 2'd2;
  localparam state_t S_RESULT = 2'd3;

  localparam logic PRED_CAT = 1'b0;
  localparam logic PRED_DOG = 1'b1;

endpackage

// File: rtl/cnn_image_feeder.sv
// Collects one frame of pixel bytes, starts the CNN core, and returns its prediction.
// Start follows the last byte by one cycle; pixel input stalls while a frame is in the core.
module cnn_image_feeder
  import cnn_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIXEL_W-1:0]            s_pix_data,
  input  logic                          s_pix_valid,
  input  logic                          s_pix_last,
  output logic                          s_pix_ready,
  output logic [NUM_PIXELS*PIXEL_W-1:0] image_data_packed,
  output logic                          cnn_start,
  input  logic                          cnn_done,
  input  logic                          cnn_prediction,
  output logic                          res_pred,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          frame_err,
  output logic                          busy,
  output logic [FRAME_CNT_W-1:0]        frames_done
);

  localparam int               IMG_W    = NUM_PIXELS * PIXEL_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [IMG_W-1:0]       img_q;
  logic                   res_pred_q, res_valid_q, frame_err_q, frame_err_d;
  logic [FRAME_CNT_W-1:0] frames_q;
  logic                   pix_xfer, at_last, res_xfer;

  assign pix_xfer = s_pix_valid & s_pix_ready;
  assign at_last  = (pix_cnt_q == LAST_IDX);
  assign res_xfer = res_valid_q & res_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   if (pix_xfer && at_last && s_pix_last) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (cnn_done) state_d = S_RESULT;
      S_RESULT: if (res_xfer) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  // Reset gates the decoded outputs so they read as reset values during the reset cycle itself.
  always_comb begin
    s_pix_ready = 1'b0;
    cnn_start   = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      s_pix_ready = (state_q == S_LOAD);
      cnn_start   = (state_q == S_START);
      busy        = (state_q != S_LOAD);
    end
  end

  // Any length mismatch (early last, or missing last on the final slot) restarts the frame at slot 0.
  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    frame_err_d = 1'b0;
    if (pix_xfer) begin
      frame_err_d = at_last ^ s_pix_last;
      if (at_last || s_pix_last) pix_cnt_d = '0;
      else                       pix_cnt_d = pix_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_q   <= '0;
      img_q       <= '0;
      frame_err_q <= 1'b0;
      res_pred_q  <= PRED_CAT;
      res_valid_q <= 1'b0;
      frames_q    <= '0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      frame_err_q <= frame_err_d;
      if (pix_xfer) img_q[int'(pix_cnt_q) * PIXEL_W +: PIXEL_W] <= s_pix_data;
      if (state_q == S_WAIT && cnn_done) begin
        res_pred_q  <= cnn_prediction;
        res_valid_q <= 1'b1;
      end
      if (res_xfer) begin
        res_valid_q <= 1'b0;
        frames_q    <= frames_q + FRAME_CNT_W'(1);
      end
    end
  end

  assign image_data_packed = img_q;
  assign res_pred          = res_pred_q;
  assign res_valid         = res_valid_q;
  assign frame_err         = frame_err_q;
  assign frames_done       = frames_q;

endmodule
